// File: rtl/alu_ctrl_if.sv
// alu_ctrl_if: instruction handshake and datapath control bundle.
// master drives s/ins, slave (the controller) drives everything else.
interface alu_ctrl_if;
    logic        s;
    logic [15:0] ins;
    logic        w;
    logic [2:0]  nsel;
    logic [2:0]  reg_num;
    logic [1:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        write;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] sximm8;
    logic        illegal;

    modport master (
        output s, ins,
        input  w, nsel, reg_num, vsel, loada, loadb, loadc, loads,
        input  write, asel, bsel, shift, ALUop, sximm8, illegal
    );

    modport slave (
        input  s, ins,
        output w, nsel, reg_num, vsel, loada, loadb, loadc, loads,
        output write, asel, bsel, shift, ALUop, sximm8, illegal
    );
endinterface

// File: rtl/alu_ctrl.sv
// alu_ctrl: Moore FSM sequencing MOV/MVN/ADD/AND/CMP on a register datapath.
// Define ALU_CTRL_CMP_EN to execute CMP; otherwise CMP decodes as illegal.
module alu_ctrl (
    input  logic      clk,
    input  logic      reset,
    alu_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        WAIT,
        DECODE,
        GET_A,
        GET_B,
        OPERATE,
        WRITE_REG,
        WRITE_IMM
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [15:0] ir;
    logic        illegal_q;
    logic        illegal_d;

    logic [2:0] opc;
    logic [1:0] op;
    logic       cmp_ok;
    logic       is_movi;
    logic       is_movr;
    logic       is_mvn;
    logic       is_add;
    logic       is_and;
    logic       is_cmp;

`ifdef ALU_CTRL_CMP_EN
    assign cmp_ok = 1'b1;
`else
    assign cmp_ok = 1'b0;
`endif

    assign opc     = ir[15:13];
    assign op      = ir[12:11];
    assign is_movi = (opc == 3'b110) && (op == 2'b10);
    assign is_movr = (opc == 3'b110) && (op == 2'b00);
    assign is_mvn  = (opc == 3'b101) && (op == 2'b11);
    assign is_add  = (opc == 3'b101) && (op == 2'b00);
    assign is_and  = (opc == 3'b101) && (op == 2'b10);
    assign is_cmp  = (opc == 3'b101) && (op == 2'b01) && cmp_ok;

    // State, captured instruction and the delayed illegal flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= WAIT;
            ir        <= 16'h0000;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_nx;
            illegal_q <= illegal_d;
            if (state == WAIT && bus.s)
                ir <= bus.ins;
        end
    end

    // Next-state selection; illegal fires in the WAIT cycle after DECODE.
    always_comb begin
        state_nx  = state;
        illegal_d = 1'b0;
        unique case (state)
            WAIT:
                if (bus.s) state_nx = DECODE;
            DECODE: begin
                if (is_movi)
                    state_nx = WRITE_IMM;
                else if (is_movr || is_mvn)
                    state_nx = GET_B;
                else if (is_add || is_and || is_cmp)
                    state_nx = GET_A;
                else begin
                    state_nx  = WAIT;
                    illegal_d = 1'b1;
                end
            end
            GET_A:     state_nx = GET_B;
            GET_B:     state_nx = OPERATE;
            OPERATE:   state_nx = is_cmp ? WAIT : WRITE_REG;
            WRITE_REG: state_nx = WAIT;
            WRITE_IMM: state_nx = WAIT;
            default:   state_nx = WAIT;
        endcase
    end

    // Moore strobes derived from state and captured instruction.
    always_comb begin
        bus.w     = 1'b0;
        bus.nsel  = 3'b000;
        bus.vsel  = 2'b00;
        bus.loada = 1'b0;
        bus.loadb = 1'b0;
        bus.loadc = 1'b0;
        bus.loads = 1'b0;
        bus.write = 1'b0;
        bus.asel  = 1'b0;
        bus.bsel  = 1'b0;
        bus.shift = 2'b00;
        bus.ALUop = 2'b00;
        unique case (state)
            WAIT:
                bus.w = 1'b1;
            WRITE_IMM: begin
                bus.nsel  = 3'b100;
                bus.vsel  = 2'b10;
                bus.write = 1'b1;
            end
            GET_A: begin
                bus.nsel  = 3'b100;
                bus.loada = 1'b1;
            end
            GET_B: begin
                bus.nsel  = 3'b001;
                bus.loadb = 1'b1;
            end
            OPERATE: begin
                bus.loadc = 1'b1;
                bus.shift = ir[4:3];
                bus.asel  = is_movr;
                bus.ALUop = is_movr ? 2'b00 : op;
                bus.loads = is_cmp;
            end
            WRITE_REG: begin
                bus.nsel  = 3'b010;
                bus.write = 1'b1;
            end
            default: ;
        endcase
    end

    // Register index follows the one-hot select.
    always_comb begin
        unique case (bus.nsel)
            3'b100:  bus.reg_num = ir[10:8];
            3'b010:  bus.reg_num = ir[7:5];
            3'b001:  bus.reg_num = ir[2:0];
            default: bus.reg_num = 3'b000;
        endcase
    end

    assign bus.sximm8  = {{8{ir[7]}}, ir[7:0]};
    assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: directed vectors against hand-computed control sequences.
// Build with or without ALU_CTRL_CMP_EN; CMP expectations follow the macro.
module tb_alu_ctrl;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;

    alu_ctrl_if bus ();

    alu_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [15:0] got,
                         input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check("strobe_excl",
              16'($countones({bus.write, bus.loada,
                              bus.loadb, bus.loadc}) <= 1),
              16'd1);
    endtask

    task automatic idle_outs(input string tag);
        check({tag, "_w"},     16'(bus.w), 16'd1);
        check({tag, "_nsel"},  16'(bus.nsel), 16'd0);
        check({tag, "_rnum"},  16'(bus.reg_num), 16'd0);
        check({tag, "_strb"},
              16'({bus.loada, bus.loadb, bus.loadc,
                   bus.loads, bus.write}), 16'd0);
        check({tag, "_sel"},
              16'({bus.vsel, bus.asel, bus.bsel,
                   bus.shift, bus.ALUop}), 16'd0);
    endtask

    // Pulse s for one edge; afterwards the DUT sits in DECODE.
    task automatic start(input logic [15:0] i);
        bus.ins = i;
        bus.s   = 1'b1;
        step();
        bus.s   = 1'b0;
        check("dec_w", 16'(bus.w), 16'd0);
        check("dec_strb",
              16'({bus.loada, bus.loadb, bus.loadc,
                   bus.loads, bus.write}), 16'd0);
    endtask

    initial begin
        n_chk   = 0;
        n_err   = 0;
        reset   = 1'b1;
        bus.s   = 1'b0;
        bus.ins = 16'h0000;
        step();
        step();
        idle_outs("rst");
        check("rst_sx8", bus.sximm8, 16'h0000);
        check("rst_ill", 16'(bus.illegal), 16'd0);

        reset = 1'b0;
        bus.s = 1'b1;
        reset = 1'b1;
        step();
        check("rst_dom_w", 16'(bus.w), 16'd1);
        step();
        check("rst_dom_w2", 16'(bus.w), 16'd1);
        bus.s = 1'b0;
        reset = 1'b0;
        step();

        // MOV R2,#5
        start(16'hD205);
        step();
        check("movi_nsel", 16'(bus.nsel), 16'd4);
        check("movi_vsel", 16'(bus.vsel), 16'd2);
        check("movi_wr", 16'(bus.write), 16'd1);
        check("movi_rnum", 16'(bus.reg_num), 16'd2);
        check("movi_sx8", bus.sximm8, 16'h0005);
        step();
        check("movi_done", 16'(bus.w), 16'd1);
        check("movi_ill", 16'(bus.illegal), 16'd0);

        // MOV R3,#-2
        start(16'hD3FE);
        step();
        check("movn_sx8", bus.sximm8, 16'hFFFE);
        check("movn_rnum", 16'(bus.reg_num), 16'd3);
        step();

        // ADD R3,R1,R1; ins scribbled and s pulsed mid-flight
        start(16'hA161);
        bus.ins = 16'hFFFF;
        bus.s   = 1'b1;
        step();
        bus.s   = 1'b0;
        check("add_a_nsel", 16'(bus.nsel), 16'd4);
        check("add_a_lda", 16'(bus.loada), 16'd1);
        check("add_a_rnum", 16'(bus.reg_num), 16'd1);
        step();
        check("add_b_nsel", 16'(bus.nsel), 16'd1);
        check("add_b_ldb", 16'(bus.loadb), 16'd1);
        step();
        check("add_op_alu", 16'(bus.ALUop), 16'd0);
        check("add_op_ldc", 16'(bus.loadc), 16'd1);
        check("add_op_asel", 16'(bus.asel), 16'd0);
        check("add_op_lds", 16'(bus.loads), 16'd0);
        step();
        check("add_wr_nsel", 16'(bus.nsel), 16'd2);
        check("add_wr_rnum", 16'(bus.reg_num), 16'd3);
        check("add_wr_wr", 16'(bus.write), 16'd1);
        check("add_wr_vsel", 16'(bus.vsel), 16'd0);
        step();
        check("add_done", 16'(bus.w), 16'd1);
        check("add_ill", 16'(bus.illegal), 16'd0);

        // MVN R2,R5,shift=01
        start(16'hB84D);
        step();
        check("mvn_b_rnum", 16'(bus.reg_num), 16'd5);
        check("mvn_b_ldb", 16'(bus.loadb), 16'd1);
        step();
        check("mvn_op_alu", 16'(bus.ALUop), 16'd3);
        check("mvn_op_sh", 16'(bus.shift), 16'd1);
        check("mvn_op_asel", 16'(bus.asel), 16'd0);
        step();
        check("mvn_wr_rnum", 16'(bus.reg_num), 16'd2);
        step();
        check("mvn_done", 16'(bus.w), 16'd1);
        check("mvn_sh_idle", 16'(bus.shift), 16'd0);

        // MOV R4,R3,shift=10
        start(16'hC093);
        step();
        check("movr_b_rnum", 16'(bus.reg_num), 16'd3);
        step();
        check("movr_op_asel", 16'(bus.asel), 16'd1);
        check("movr_op_alu", 16'(bus.ALUop), 16'd0);
        check("movr_op_sh", 16'(bus.shift), 16'd2);
        step();
        check("movr_wr_rnum", 16'(bus.reg_num), 16'd4);
        check("movr_wr_wr", 16'(bus.write), 16'd1);
        step();
        check("movr_done", 16'(bus.w), 16'd1);

        // CMP R1,R1
        start(16'hA921);
`ifdef ALU_CTRL_CMP_EN
        step();
        check("cmp_a_lda", 16'(bus.loada), 16'd1);
        step();
        check("cmp_b_ldb", 16'(bus.loadb), 16'd1);
        step();
        check("cmp_op_alu", 16'(bus.ALUop), 16'd1);
        check("cmp_op_lds", 16'(bus.loads), 16'd1);
        check("cmp_op_ldc", 16'(bus.loadc), 16'd1);
        check("cmp_op_wr", 16'(bus.write), 16'd0);
        step();
        check("cmp_done", 16'(bus.w), 16'd1);
        check("cmp_ill", 16'(bus.illegal), 16'd0);
`else
        step();
        check("cmp_ill", 16'(bus.illegal), 16'd1);
        idle_outs("cmp_idle");
        step();
        check("cmp_ill_end", 16'(bus.illegal), 16'd0);
`endif

        // Unsupported opcode
        start(16'hE000);
        check("bad_ill_dec", 16'(bus.illegal), 16'd0);
        step();
        check("bad_ill", 16'(bus.illegal), 16'd1);
        idle_outs("bad_idle");
        step();
        check("bad_ill_end", 16'(bus.illegal), 16'd0);

        // s held high: back-to-back MOV imm
        bus.ins = 16'hD205;
        bus.s   = 1'b1;
        step();
        step();
        check("b2b_wr1", 16'(bus.write), 16'd1);
        step();
        check("b2b_wait", 16'(bus.w), 16'd1);
        step();
        check("b2b_dec", 16'(bus.w), 16'd0);
        step();
        check("b2b_wr2", 16'(bus.write), 16'd1);
        bus.s = 1'b0;
        step();
        check("b2b_done", 16'(bus.w), 16'd1);

        // Reset during OPERATE of ADD
        start(16'hA161);
        step();
        step();
        step();
        check("rop_ldc", 16'(bus.loadc), 16'd1);
        reset = 1'b1;
        step();
        idle_outs("rop");
        check("rop_sx8", bus.sximm8, 16'h0000);
        reset = 1'b0;
        step();
        idle_outs("rop_post");
        step();
        check("rop_post_wr", 16'(bus.write), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
